// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain (clk2) pointer and flag controller for the asynchronous FIFO.
// It synchronizes the Gray write pointer into clk2 and owns the read pointer. It produces the
// Empty, almost_empty and fill-level flags. It also gates the consumer's Read into a safe
// storage read enable and read address.
//
// Ports
//   clk2          read-domain clock, rising edge
//   rst2_n        asynchronous active-low reset
//   wptr_gray     Gray write pointer from the write domain (asynchronous to clk2)
//   Read          consumer read request
//   Empty         registered empty flag
//   almost_empty  registered, rd_count <= AE_THRESH
//   rd_count      registered number of entries available, 0..DEPTH
//   rd_en         storage read enable, Read & !Empty
//   rd_addr       storage read address, low PTR_WIDTH bits of the binary read pointer
//   rd_valid      storage data valid (rd_en delayed one cycle)
//   rptr_gray     registered Gray read pointer, exported to the write domain
//   underflow     sticky, set by Read while Empty; cleared only by reset
module fifo_read_ctrl #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PTR_WIDTH = 9,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                 clk2,
  input  logic                 rst2_n,
  input  logic [PTR_WIDTH:0]   wptr_gray,
  input  logic                 Read,
  output logic                 Empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rd_count,
  output logic                 rd_en,
  output logic [PTR_WIDTH-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [PTR_WIDTH:0]   rptr_gray,
  output logic                 underflow
);

  if (DEPTH != (32'd1 << PTR_WIDTH)) begin : g_depth_check
    $error("fifo_read_ctrl: DEPTH must equal 2**PTR_WIDTH");
  end

  localparam logic [PTR_WIDTH:0] AeThresh = (PTR_WIDTH + 1)'(AE_THRESH);

  logic [PTR_WIDTH:0] wq1_q, wq2_q;
  logic [PTR_WIDTH:0] wq2_bin;
  logic [PTR_WIDTH:0] rptr_bin_q, rptr_bin_d;
  logic [PTR_WIDTH:0] rptr_gray_q, rptr_gray_d;
  logic [PTR_WIDTH:0] rd_count_q, rd_count_d;
  logic               empty_q, empty_d;
  logic               almost_empty_q, almost_empty_d;
  logic               rd_valid_q;
  logic               underflow_q, underflow_d;

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    wq2_bin = '0;
    for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
      wq2_bin[i] = ^(wq2_q >> i);
    end
  end

  // Gated by the registered flag, so a read can never pass the synchronized write pointer.
  assign rd_en = Read & ~empty_q;

  always_comb begin
    rptr_bin_d     = rptr_bin_q + (PTR_WIDTH + 1)'(rd_en);
    rptr_gray_d    = rptr_bin_d ^ (rptr_bin_d >> 1);
    // The flags look at the post-read pointer, so a consumed entry is never seen as still present.
    empty_d        = (rptr_gray_d == wq2_q);
    rd_count_d     = wq2_bin - rptr_bin_d;
    almost_empty_d = (rd_count_d <= AeThresh);
    underflow_d    = underflow_q | (Read & empty_q);
  end

  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) begin
      wq1_q          <= '0;
      wq2_q          <= '0;
      rptr_bin_q     <= '0;
      rptr_gray_q    <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wq1_q          <= wptr_gray;
      wq2_q          <= wq1_q;
      rptr_bin_q     <= rptr_bin_d;
      rptr_gray_q    <= rptr_gray_d;
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_en;
      underflow_q    <= underflow_d;
    end
  end

  assign Empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;
  assign rd_addr      = rptr_bin_q[PTR_WIDTH-1:0];
  assign rd_valid     = rd_valid_q;
  assign rptr_gray    = rptr_gray_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl (DEPTH 512, PTR_WIDTH 9, AE_THRESH 4).
// The reference model tracks the pointers as plain integers. It derives every output from
// pointer differences, and the compare process checks all outputs on each falling edge.
// The directed sections add literal expectations that pin the model itself.
module tb_fifo_read_ctrl;

  logic       clk2 = 1'b0;
  logic       rst2_n = 1'b0;
  logic [9:0] wp_bin = '0;
  logic [9:0] wptr_gray;
  logic       Read = 1'b0;
  logic       Empty, almost_empty, rd_en, rd_valid, underflow;
  logic [9:0] rd_count, rptr_gray;
  logic [8:0] rd_addr;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [9:0] gray(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wptr_gray = gray(wp_bin);

  always #5 clk2 = ~clk2;

  fifo_read_ctrl #(
    .DEPTH    (512),
    .PTR_WIDTH(9),
    .AE_THRESH(4)
  ) dut (
    .clk2        (clk2),
    .rst2_n      (rst2_n),
    .wptr_gray   (wptr_gray),
    .Read        (Read),
    .Empty       (Empty),
    .almost_empty(almost_empty),
    .rd_count    (rd_count),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rptr_gray   (rptr_gray),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: integer pointers; the write pointer reaches the read side two edges late.
  int   m_w1 = 0, m_w2 = 0, m_rptr = 0, m_count = 0;
  logic m_empty = 1'b1, m_ae = 1'b1, m_valid = 1'b0, m_uflow = 1'b0;
  logic model_en;
  assign model_en = Read && !m_empty;

  always @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) begin
      m_w1 <= 0; m_w2 <= 0; m_rptr <= 0; m_count <= 0;
      m_empty <= 1'b1; m_ae <= 1'b1; m_valid <= 1'b0; m_uflow <= 1'b0;
    end else begin
      m_w1    <= int'(wp_bin);
      m_w2    <= m_w1;
      m_rptr  <= (m_rptr + int'(model_en)) & 1023;
      m_count <= (m_w2 - m_rptr - int'(model_en)) & 1023;
      m_empty <= (((m_w2 - m_rptr - int'(model_en)) & 1023) == 0);
      m_ae    <= (((m_w2 - m_rptr - int'(model_en)) & 1023) <= 4);
      m_valid <= model_en;
      m_uflow <= m_uflow | (Read & m_empty);
    end
  end

  always @(negedge clk2) begin
    chk("Empty",        int'(Empty),        int'(m_empty));
    chk("almost_empty", int'(almost_empty), int'(m_ae));
    chk("rd_count",     int'(rd_count),     m_count);
    chk("rd_en",        int'(rd_en),        int'(model_en));
    chk("rd_addr",      int'(rd_addr),      m_rptr & 511);
    chk("rd_valid",     int'(rd_valid),     int'(m_valid));
    chk("rptr_gray",    int'(rptr_gray),    int'(gray(10'(m_rptr))));
    chk("underflow",    int'(underflow),    int'(m_uflow));
  end

  // Inputs change 2 time units after the rising edge; literal checks sample 1 unit later.
  task automatic tick();
    @(posedge clk2);
    #2;
  endtask

  task automatic do_reset();
    Read = 1'b0;
    wp_bin = '0;
    rst2_n = 1'b0;
    tick();
    tick();
    rst2_n = 1'b1;
    tick();
  endtask

  initial begin
    do_reset();
    #1;
    chk("reset Empty", int'(Empty), 1);
    chk("reset rd_count", int'(rd_count), 0);

    // Sync latency: one write shows up on the third edge.
    wp_bin = 10'd1;
    tick(); #1; chk("sync edge1 Empty", int'(Empty), 1);
    tick(); #1; chk("sync edge2 Empty", int'(Empty), 1);
    tick(); #1;
    chk("sync edge3 Empty", int'(Empty), 0);
    chk("sync rd_count", int'(rd_count), 1);
    chk("sync almost_empty", int'(almost_empty), 1);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    #1; chk("single read Empty", int'(Empty), 1);

    // Burst drain of 8 entries with Read held, running into underflow.
    do_reset();
    wp_bin = 10'd8;
    repeat (3) tick();
    Read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("burst rd_en", int'(rd_en), (i < 8) ? 1 : 0);
      if (i < 8) chk("burst rd_addr", int'(rd_addr), i);
      chk("burst rd_valid", int'(rd_valid), (i >= 1 && i <= 8) ? 1 : 0);
      tick();
    end
    Read = 1'b0;
    #1;
    chk("drain Empty", int'(Empty), 1);
    chk("drain rd_count", int'(rd_count), 0);
    chk("drain rptr_gray", int'(rptr_gray), 'h00C);
    chk("underflow set", int'(underflow), 1);
    repeat (3) tick();
    #1; chk("underflow sticky", int'(underflow), 1);

    // Asynchronous reset in the middle of a burst.
    wp_bin = 10'd20;
    repeat (3) tick();
    Read = 1'b1;
    tick();
    tick();
    #1; chk("pre-reset rd_en", int'(rd_en), 1);
    rst2_n = 1'b0;
    #1;
    chk("async reset Empty", int'(Empty), 1);
    chk("async reset rd_count", int'(rd_count), 0);
    chk("async reset rptr_gray", int'(rptr_gray), 0);
    chk("async reset rd_valid", int'(rd_valid), 0);
    chk("async reset underflow", int'(underflow), 0);
    chk("async reset rd_en", int'(rd_en), 0);
    Read = 1'b0;
    wp_bin = '0;
    tick();
    tick();
    rst2_n = 1'b1;
    tick();
    #1; chk("post-reset rd_valid", int'(rd_valid), 0);

    // Wrap and full: move the read pointer to 510, then fill to 512 entries.
    wp_bin = 10'd510;
    repeat (3) tick();
    Read = 1'b1;
    repeat (510) tick();
    Read = 1'b0;
    #1;
    chk("preset Empty", int'(Empty), 1);
    chk("preset rd_addr", int'(rd_addr), 510);
    wp_bin = 10'd1022;
    repeat (3) tick();
    #1;
    chk("full rd_count", int'(rd_count), 512);
    chk("full Empty", int'(Empty), 0);
    chk("full almost_empty", int'(almost_empty), 0);
    Read = 1'b1;
    for (int k = 0; k < 512; k++) begin
      #1;
      chk("wrap rd_addr", int'(rd_addr), (510 + k) % 512);
      tick();
    end
    Read = 1'b0;
    #1;
    chk("wrap Empty", int'(Empty), 1);
    chk("wrap rd_count", int'(rd_count), 0);
    chk("wrap rptr_gray", int'(rptr_gray), 'h201);
    chk("wrap underflow", int'(underflow), 0);

    // Concurrent: the writer runs two cycles ahead of the reader, so the level holds at 5.
    wp_bin = 10'd1027;
    repeat (3) tick();
    #1;
    chk("conc start rd_count", int'(rd_count), 5);
    chk("conc start almost_empty", int'(almost_empty), 0);
    for (int k = 0; k < 12; k++) begin
      wp_bin = wp_bin + 10'd1;
      Read = (k >= 2);
      tick();
    end
    #1;
    chk("conc rd_count", int'(rd_count), 5);
    chk("conc almost_empty", int'(almost_empty), 0);
    chk("conc Empty", int'(Empty), 0);
    chk("conc underflow", int'(underflow), 0);
    Read = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
